// File: rtl/commit_trace_fifo.sv
// Retirement recorder: tags each commit with an instruction number and buffers it
// in a show-ahead FIFO drained by a valid/ready consumer, with cycle/instruction counters.
module commit_trace_fifo #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 32,
  parameter int LOG_NOP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cm_valid,
  input  logic [DATA_W-1:0]          cm_pc,
  input  logic                       cm_reg_wr,
  input  logic [REG_W-1:0]           cm_reg_sel,
  input  logic [DATA_W-1:0]          cm_reg_data,
  input  logic                       cm_mem_rd,
  input  logic                       cm_mem_wr,
  input  logic [DATA_W-1:0]          cm_mem_addr,
  input  logic [DATA_W-1:0]          cm_mem_data,
  input  logic                       cm_halt,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [CNT_W-1:0]           tr_inum,
  output logic [DATA_W-1:0]          tr_pc,
  output logic                       tr_reg_wr,
  output logic [REG_W-1:0]           tr_reg_sel,
  output logic [DATA_W-1:0]          tr_reg_data,
  output logic                       tr_mem_rd,
  output logic                       tr_mem_wr,
  output logic [DATA_W-1:0]          tr_mem_addr,
  output logic [DATA_W-1:0]          tr_mem_data,
  output logic                       tr_halt,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           inst_count,
  output logic                       halted,
  output logic                       overflow
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic              regWr;
    logic [REG_W-1:0]  regSel;
    logic [DATA_W-1:0] regData;
    logic              memRd;
    logic              memWr;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic              halt;
  } recordT;

  recordT            memArray [DEPTH];
  logic [PTR_W-1:0]  rdPtrReg;
  logic [PTR_W-1:0]  wrPtrReg;
  logic [LVL_W-1:0]  levelReg;
  logic [LVL_W-1:0]  levelNext;
  logic [CNT_W-1:0]  cycleCountReg;
  logic [CNT_W-1:0]  instCountReg;
  logic              haltedReg;
  logic              overflowReg;

  logic   accept;
  logic   sideEffect;
  logic   eligible;
  logic   push;
  logic   pop;
  logic   full;
  logic   notEmpty;
  logic   doWrite;
  logic   doDrop;
  logic   memRdNorm;
  recordT newRecord;
  recordT headRecord;

  assign notEmpty   = (levelReg != '0);
  assign full       = (levelReg == LVL_W'(DEPTH));
  assign accept     = cm_valid & ~haltedReg;
  assign sideEffect = cm_reg_wr | cm_mem_wr | cm_halt;
  assign eligible   = (LOG_NOP != 0) | sideEffect;
  assign push       = accept & eligible;
  assign pop        = notEmpty & tr_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign doWrite    = push & (~full | pop);
  assign doDrop     = push & full & ~pop;
  assign memRdNorm  = cm_mem_rd & cm_reg_wr & ~cm_mem_wr;

  always_comb begin
    levelNext = levelReg;
    if (doWrite && !pop) begin
      levelNext = levelReg + LVL_W'(1);
    end else if (pop && !doWrite) begin
      levelNext = levelReg - LVL_W'(1);
    end
  end

  always_comb begin
    newRecord       = '0;
    newRecord.inum  = instCountReg;
    newRecord.pc    = cm_pc;
    newRecord.regWr = cm_reg_wr;
    newRecord.memRd = memRdNorm;
    newRecord.memWr = cm_mem_wr;
    newRecord.halt  = cm_halt;
    if (cm_reg_wr) begin
      newRecord.regSel  = cm_reg_sel;
      newRecord.regData = cm_reg_data;
    end
    // Address/data only carry meaning for an actual memory access.
    if (memRdNorm || cm_mem_wr) begin
      newRecord.memAddr = cm_mem_addr;
      newRecord.memData = cm_mem_data;
    end
  end

  // Storage is deliberately not reset: occupancy lives in levelReg and the
  // outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      memArray[wrPtrReg] <= newRecord;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtrReg      <= '0;
      wrPtrReg      <= '0;
      levelReg      <= '0;
      cycleCountReg <= '0;
      instCountReg  <= '0;
      haltedReg     <= 1'b0;
      overflowReg   <= 1'b0;
    end else begin
      if (doWrite) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (pop) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
      levelReg <= levelNext;
      if (!haltedReg) begin
        cycleCountReg <= cycleCountReg + CNT_W'(1);
      end
      if (accept) begin
        instCountReg <= instCountReg + CNT_W'(1);
        if (cm_halt) begin
          haltedReg <= 1'b1;
        end
      end
      if (doDrop) begin
        overflowReg <= 1'b1;
      end
    end
  end

  always_comb begin
    headRecord = '0;
    if (notEmpty) begin
      headRecord = memArray[rdPtrReg];
    end
  end

  assign tr_valid    = notEmpty;
  assign tr_inum     = headRecord.inum;
  assign tr_pc       = headRecord.pc;
  assign tr_reg_wr   = headRecord.regWr;
  assign tr_reg_sel  = headRecord.regSel;
  assign tr_reg_data = headRecord.regData;
  assign tr_mem_rd   = headRecord.memRd;
  assign tr_mem_wr   = headRecord.memWr;
  assign tr_mem_addr = headRecord.memAddr;
  assign tr_mem_data = headRecord.memData;
  assign tr_halt     = headRecord.halt;

  assign level       = levelReg;
  assign cycle_count = cycleCountReg;
  assign inst_count  = instCountReg;
  assign halted      = haltedReg;
  assign overflow    = overflowReg;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Randomized bench for commit_trace_fifo: two instances (LOG_NOP=1 and 0) checked
// every cycle against a queue-based reference model, plus directed literal checks.
module tb_commit_trace_fifo;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] inum;
    logic [15:0] pc;
    logic        regWr;
    logic [2:0]  regSel;
    logic [15:0] regData;
    logic        memRd;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] memData;
    logic        halt;
  } rec_t;

  logic        clk;
  logic        rst = 1'b1;
  logic        cm_valid = 1'b0;
  logic [15:0] cm_pc = '0;
  logic        cm_reg_wr = 1'b0;
  logic [2:0]  cm_reg_sel = '0;
  logic [15:0] cm_reg_data = '0;
  logic        cm_mem_rd = 1'b0;
  logic        cm_mem_wr = 1'b0;
  logic [15:0] cm_mem_addr = '0;
  logic [15:0] cm_mem_data = '0;
  logic        cm_halt = 1'b0;
  logic        tr_ready = 1'b0;

  logic        trValid   [2];
  logic [31:0] trInum    [2];
  logic [15:0] trPc      [2];
  logic        trRegWr   [2];
  logic [2:0]  trRegSel  [2];
  logic [15:0] trRegData [2];
  logic        trMemRd   [2];
  logic        trMemWr   [2];
  logic [15:0] trMemAddr [2];
  logic [15:0] trMemData [2];
  logic        trHalt    [2];
  logic [3:0]  lvl       [2];
  logic [31:0] cycCnt    [2];
  logic [31:0] insCnt    [2];
  logic        hlt       [2];
  logic        ovf       [2];

  int vectors = 0;
  int miscompares = 0;
  bit armed = 0;
  bit verbose = 1;

  // reference model state
  rec_t        mq     [2][$];
  rec_t        popLog [2][$];
  bit          mOvf   [2];
  logic [31:0] mCycle = '0;
  logic [31:0] mInst = '0;
  bit          mHalted = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gDut
    commit_trace_fifo #(
      .DATA_W(16), .REG_W(3), .DEPTH(DEPTH), .CNT_W(32), .LOG_NOP(gi == 0 ? 1 : 0)
    ) dut (
      .clk(clk), .rst(rst),
      .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_reg_wr(cm_reg_wr), .cm_reg_sel(cm_reg_sel),
      .cm_reg_data(cm_reg_data), .cm_mem_rd(cm_mem_rd), .cm_mem_wr(cm_mem_wr),
      .cm_mem_addr(cm_mem_addr), .cm_mem_data(cm_mem_data), .cm_halt(cm_halt),
      .tr_valid(trValid[gi]), .tr_ready(tr_ready), .tr_inum(trInum[gi]), .tr_pc(trPc[gi]),
      .tr_reg_wr(trRegWr[gi]), .tr_reg_sel(trRegSel[gi]), .tr_reg_data(trRegData[gi]),
      .tr_mem_rd(trMemRd[gi]), .tr_mem_wr(trMemWr[gi]), .tr_mem_addr(trMemAddr[gi]),
      .tr_mem_data(trMemData[gi]), .tr_halt(trHalt[gi]),
      .level(lvl[gi]), .cycle_count(cycCnt[gi]), .inst_count(insCnt[gi]),
      .halted(hlt[gi]), .overflow(ovf[gi])
    );
  end

  task automatic chk(string nm, int k, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[u%0d]: got %0h expected %0h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  function automatic rec_t dutRec(int k);
    rec_t r;
    r.inum = trInum[k];       r.pc = trPc[k];
    r.regWr = trRegWr[k];     r.regSel = trRegSel[k];   r.regData = trRegData[k];
    r.memRd = trMemRd[k];     r.memWr = trMemWr[k];
    r.memAddr = trMemAddr[k]; r.memData = trMemData[k]; r.halt = trHalt[k];
    return r;
  endfunction

  // Expected stored record for the commit currently on the cm_* inputs.
  function automatic rec_t mkRec(logic [31:0] inum);
    rec_t r;
    r = '0;
    r.inum = inum;
    r.pc = cm_pc;
    r.regWr = cm_reg_wr;
    if (cm_reg_wr) begin
      r.regSel = cm_reg_sel;
      r.regData = cm_reg_data;
    end
    r.memWr = cm_mem_wr;
    r.memRd = cm_mem_rd && cm_reg_wr && !cm_mem_wr;
    if (r.memRd || r.memWr) begin
      r.memAddr = cm_mem_addr;
      r.memData = cm_mem_data;
    end
    r.halt = cm_halt;
    return r;
  endfunction

  // Model: advance on each clock, clear on reset.
  initial begin
    bit   acc;
    bit   elig;
    rec_t r;
    mOvf[0] = 0;
    mOvf[1] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mCycle = '0;
        mInst = '0;
        mHalted = 0;
        for (int k = 0; k < 2; k++) begin
          mq[k].delete();
          mOvf[k] = 0;
        end
      end else begin
        acc = cm_valid && !mHalted;
        r = mkRec(mInst);
        for (int k = 0; k < 2; k++) begin
          elig = (k == 0) || cm_reg_wr || cm_mem_wr || cm_halt;
          if (mq[k].size() > 0 && tr_ready) void'(mq[k].pop_front());
          if (acc && elig) begin
            if (mq[k].size() < DEPTH) mq[k].push_back(r);
            else mOvf[k] = 1;
          end
        end
        if (!mHalted) mCycle = mCycle + 32'd1;
        if (acc) begin
          mInst = mInst + 32'd1;
          if (cm_halt) mHalted = 1;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs of both instances.
  initial begin
    rec_t expHead;
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          expHead = '0;
          if (mq[k].size() > 0) expHead = mq[k][0];
          chk("tr_valid", k, trValid[k], mq[k].size() != 0);
          chk("level", k, lvl[k], mq[k].size());
          chk("head", k, dutRec(k), expHead);
          chk("overflow", k, ovf[k], mOvf[k]);
          chk("cycle_count", k, cycCnt[k], mCycle);
          chk("inst_count", k, insCnt[k], mInst);
          chk("halted", k, hlt[k], mHalted);
          if (!rst && trValid[k] && tr_ready) begin
            popLog[k].push_back(dutRec(k));
            if (verbose)
              $display("pop u%0d inum=%0d pc=%04h rw=%b sel=%0d rd=%04h mr=%b mw=%b ma=%04h md=%04h h=%b",
                       k, trInum[k], trPc[k], trRegWr[k], trRegSel[k], trRegData[k],
                       trMemRd[k], trMemWr[k], trMemAddr[k], trMemData[k], trHalt[k]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    cm_valid = 1'b0;
    cm_halt = 1'b0;
    repeat (n) tick();
  endtask

  task automatic resetDut();
    cm_valid = 1'b0;
    cm_halt = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) popLog[k].delete();
  endtask

  task automatic commit(logic [15:0] pc, logic rw, logic [2:0] sel, logic [15:0] rd,
                        logic mr, logic mw, logic [15:0] ma, logic [15:0] md, logic h);
    cm_valid = 1'b1;
    cm_pc = pc; cm_reg_wr = rw; cm_reg_sel = sel; cm_reg_data = rd;
    cm_mem_rd = mr; cm_mem_wr = mw; cm_mem_addr = ma; cm_mem_data = md; cm_halt = h;
    tick();
    cm_valid = 1'b0;
    cm_halt = 1'b0;
  endtask

  initial begin
    int haltAge;
    int readyBias;
    tick();
    armed = 1;

    // basic ordering and record normalisation
    resetDut();
    tr_ready = 1'b1;
    commit(16'h0000, 1, 3'd1, 16'h0005, 0, 0, 16'h1234, 16'h5678, 0);
    commit(16'h0002, 0, 3'd4, 16'hAAAA, 1, 1, 16'h0010, 16'hBEEF, 0);
    commit(16'h0004, 0, 3'd0, 16'h0000, 1, 0, 16'h0055, 16'h0066, 0);
    idle(3);
    chk("t1 pops", 0, popLog[0].size(), 3);
    chk("t1 nop-filtered pops", 1, popLog[1].size(), 2);
    chk("t1 inst_count", 0, insCnt[0], 3);
    chk("t1 overflow", 0, ovf[0], 0);
    if (popLog[0].size() == 3) begin
      chk("t1 inum0", 0, popLog[0][0].inum, 0);
      chk("t1 inum1", 0, popLog[0][1].inum, 1);
      chk("t1 inum2", 0, popLog[0][2].inum, 2);
      chk("t1 rec0 sel", 0, popLog[0][0].regSel, 1);
      chk("t1 rec0 data", 0, popLog[0][0].regData, 16'h0005);
      chk("t1 rec0 addr zeroed", 0, popLog[0][0].memAddr, 0);
      chk("t1 rec1 store", 0, {popLog[0][1].memWr, popLog[0][1].memRd}, 2'b10);
      chk("t1 rec1 addr", 0, popLog[0][1].memAddr, 16'h0010);
      chk("t1 rec1 data", 0, popLog[0][1].memData, 16'hBEEF);
      chk("t1 rec1 regdata zeroed", 0, popLog[0][1].regData, 0);
      chk("t1 rec2 pc", 0, popLog[0][2].pc, 16'h0004);
      chk("t1 rec2 mem zeroed", 0, {popLog[0][2].memRd, popLog[0][2].memAddr}, 0);
    end

    // LOG_NOP=0: reg, NOP, reg
    resetDut();
    commit(16'h0000, 1, 3'd2, 16'h0011, 0, 0, 0, 0, 0);
    commit(16'h0002, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 0);
    commit(16'h0004, 1, 3'd3, 16'h0022, 0, 0, 0, 0, 0);
    idle(3);
    chk("t2 pops", 1, popLog[1].size(), 2);
    if (popLog[1].size() == 2) begin
      chk("t2 inum first", 1, popLog[1][0].inum, 0);
      chk("t2 inum second", 1, popLog[1][1].inum, 2);
    end
    chk("t2 inst_count", 1, insCnt[1], 3);

    // fill, push+pop at full, overflow, drain
    resetDut();
    tr_ready = 1'b0;
    for (int i = 0; i < 8; i++) commit(16'(2 * i), 1, 3'(i), 16'(i + 100), 0, 0, 0, 0, 0);
    chk("t3 level full", 0, lvl[0], 8);
    chk("t3 no overflow yet", 0, ovf[0], 0);
    tr_ready = 1'b1;
    commit(16'h0010, 1, 3'd7, 16'h0777, 0, 0, 0, 0, 0);
    tr_ready = 1'b0;
    chk("t4 level after push+pop", 0, lvl[0], 8);
    chk("t4 overflow after push+pop", 0, ovf[0], 0);
    commit(16'h0012, 1, 3'd1, 16'h0001, 0, 0, 0, 0, 0);
    commit(16'h0014, 1, 3'd1, 16'h0002, 0, 0, 0, 0, 0);
    chk("t3 overflow", 0, ovf[0], 1);
    chk("t3 inst_count", 0, insCnt[0], 11);
    tr_ready = 1'b1;
    idle(12);
    chk("t3 drained valid", 0, trValid[0], 0);
    chk("t3 pops", 0, popLog[0].size(), 9);
    for (int i = 0; i < popLog[0].size(); i++) chk("t3 drain inum", 0, popLog[0][i].inum, i);

    // halt on the fifth commit, cm_valid held afterwards
    resetDut();
    for (int i = 0; i < 4; i++) commit(16'(16'h0018 + 2 * i), 1, 3'd1, 16'(i), 0, 0, 0, 0, 0);
    commit(16'h0020, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) commit(16'(16'h0030 + 2 * i), 1, 3'd2, 16'h00FF, 0, 0, 0, 0, 0);
    idle(3);
    chk("t5 halted", 0, hlt[0], 1);
    chk("t5 inst frozen", 0, insCnt[0], 5);
    chk("t5 cycle frozen", 0, cycCnt[0], 5);
    chk("t5 pops", 0, popLog[0].size(), 5);
    if (popLog[0].size() == 5) begin
      chk("t5 last halt", 0, popLog[0][4].halt, 1);
      chk("t5 last pc", 0, popLog[0][4].pc, 16'h0020);
    end

    // asynchronous reset between edges with 5 entries queued
    resetDut();
    tr_ready = 1'b0;
    for (int i = 0; i < 5; i++) commit(16'(2 * i), 1, 3'd1, 16'(i), 0, 0, 0, 0, 0);
    chk("t6 level before", 0, lvl[0], 5);
    #1 rst = 1'b1;
    #1;
    chk("t6 level", 0, lvl[0], 0);
    chk("t6 valid", 0, trValid[0], 0);
    chk("t6 cycle", 0, cycCnt[0], 0);
    chk("t6 inst", 0, insCnt[0], 0);
    chk("t6 flags", 0, {hlt[0], ovf[0]}, 0);
    tick();
    rst = 1'b0;

    // randomized phase
    verbose = 0;
    resetDut();
    haltAge = 0;
    readyBias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) readyBias = $urandom_range(0, 100);
      tr_ready = ($urandom_range(0, 99) < readyBias);
      cm_valid = ($urandom_range(0, 3) != 0);
      cm_pc = 16'($urandom);
      cm_reg_wr = $urandom_range(0, 1);
      cm_reg_sel = 3'($urandom);
      cm_reg_data = 16'($urandom);
      cm_mem_rd = ($urandom_range(0, 9) < 3);
      cm_mem_wr = ($urandom_range(0, 3) == 0);
      cm_mem_addr = 16'($urandom);
      cm_mem_data = 16'($urandom);
      cm_halt = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
      if (mHalted) haltAge++;
      if (haltAge > 20) begin
        haltAge = 0;
        resetDut();
      end
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Parametrised, synthesizable retirement recorder for pipelined versions of the processor.
- Captures one commit event per cycle from the writeback stage: PC, register write, memory access, halt.
- Tags each event with an instruction number and buffers it in a show-ahead FIFO, drained by a valid/ready consumer (trace dumper, debug port).
- Tracks cycle and instruction counts. Freezes on halt. Flags lost records.

Parameters:
- DATA_W, 16, width of PC, register data, memory address and memory data.
- REG_W, 3, register-select width.
- DEPTH, 8, FIFO entries; power of 2, >= 2.
- CNT_W, 32, width of the cycle counter, the instruction counter and tr_inum.
- LOG_NOP, 1, 1 = enqueue commits with no side effect (branch/NOP); 0 = count them but do not enqueue.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cm_valid  in  1  an instruction retires this cycle.
- cm_pc  in  DATA_W  PC of the retiring instruction.
- cm_reg_wr  in  1  register file written.
- cm_reg_sel  in  REG_W  destination register.
- cm_reg_data  in  DATA_W  register write data.
- cm_mem_rd  in  1  load.
- cm_mem_wr  in  1  store.
- cm_mem_addr  in  DATA_W  memory address.
- cm_mem_data  in  DATA_W  store data.
- cm_halt  in  1  halt retiring.
- tr_valid  out  1  head record available.
- tr_ready  in  1  consumer accepts head record.
- tr_inum  out  CNT_W  instruction number of head record.
- tr_pc, tr_reg_wr, tr_reg_sel, tr_reg_data, tr_mem_rd, tr_mem_wr, tr_mem_addr, tr_mem_data, tr_halt  out  (widths as cm_*)  head record fields.
- level  out  $clog2(DEPTH+1)  current occupancy.
- cycle_count  out  CNT_W  cycles since reset.
- inst_count  out  CNT_W  accepted commits.
- halted  out  1  halt commit accepted.
- overflow  out  1  sticky: at least one record dropped.

Behaviour:
- Reset (async, rst=1): FIFO emptied, level=0, tr_valid=0, cycle_count=0, inst_count=0, halted=0, overflow=0.
  - tr_* data outputs = 0 while empty.
  - Takes effect immediately, mid-operation included; in-flight records are discarded.
- cycle_count increments every clock while !halted; wraps modulo 2^CNT_W. Freezes on the cycle after the halt commit.
- Accept = cm_valid & !halted.
  - Each accepted commit gets inum = inst_count (pre-increment). inst_count increments by 1 and wraps.
- Record normalisation:
  - mem_wr=1 forces the stored mem_rd=0.
  - mem_rd is stored as cm_mem_rd & cm_reg_wr.
  - reg_data/reg_sel are stored as 0 when reg_wr=0.
  - mem_addr/mem_data are stored as 0 when neither mem_rd nor mem_wr is set.
- Side-effect-free commit (reg_wr=0, mem_wr=0, halt=0): enqueued only if LOG_NOP=1; always counted.
- Push: accepted, enqueue-eligible commit.
- Pop: tr_valid & tr_ready.
- tr_valid = (level != 0). Head record is stable while tr_valid & !tr_ready.
- Latency: push into an empty FIFO gives tr_valid=1 on the next cycle. No bypass.
- Simultaneous push and pop:
  - Allowed at any level, including full (the pop frees the slot).
  - level unchanged.
  - Ordering preserved.
- Push when full with no pop:
  - Record dropped and overflow set (sticky until rst).
  - inst_count still increments, so tr_inum gaps expose the loss.
- Pop when empty: ignored. tr_ready while empty has no effect.
- Halt commit:
  - halted=1 from the next cycle. Further cm_valid ignored (no count, no push).
  - The halt record is enqueued like any other and is droppable on full with overflow set; halted is set regardless.
- After halt, the consumer continues draining. tr_halt=1 marks the final record.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally. Full/empty are derived from level.

Test Plan:
- Reset, then 3 commits (PC 0x0000 reg_wr r1=0x0005; PC 0x0002 store addr 0x0010 data 0xBEEF; PC 0x0004 NOP), tr_ready=1 -> records inum 0,1,2 in order; tr_valid one cycle after each push; inst_count=3; overflow=0.
- LOG_NOP=0, commits reg, NOP, reg -> only 2 records, tr_inum 0 and 2; inst_count=3.
- tr_ready=0, DEPTH=8, 10 reg commits -> level=8; overflow=1; inst_count=10; draining yields inum 0..7 then tr_valid=0.
- Full FIFO, one cycle with push and tr_ready=1 -> level stays 8; no overflow; new record appears last (inum 8).
- Commit halt at PC 0x0020 on cycle 5, cm_valid held high afterwards -> halted=1 from cycle 6; inst_count and cycle_count frozen; last drained record has tr_halt=1, tr_pc=0x0020.
- Assert rst asynchronously (between edges) with level=5 -> level, tr_valid, counters, overflow and halted all 0 before the next clk edge.
